// File: rtl/wb_stage_pkg.sv
// Shared writeback-stage encodings: result-source select and load funct3 codes.
package wb_stage_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_RSV = 2'b11
    } wb_sel_e;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_D  = 3'b011;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;
    localparam logic [2:0] LD_WU = 3'b110;

endpackage

// File: rtl/wb_stage_load_align.sv
// Little-endian load extraction from a raw doubleword, with sign/zero extension and misalignment flag.
module load_align #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misalign
);
    import wb_stage_pkg::*;

    logic [XLEN-1:0]   shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] word_s;

    // Bring the addressed byte down to bit 0; bytes past the top shift in as zero.
    assign shifted = rdata >> {off, 3'b000};
    assign byte_s  = shifted[7:0];
    assign half_s  = shifted[15:0];
    assign word_s  = shifted[31:0];

    always_comb begin
        data     = rdata;
        misalign = 1'b0;
        case (funct3)
            LD_B:  data = {{(XLEN-8){byte_s[7]}}, byte_s};
            LD_H:  begin
                data     = {{(XLEN-16){half_s[15]}}, half_s};
                misalign = off[0];
            end
            LD_W:  begin
                data     = {{(XLEN-32){word_s[31]}}, word_s};
                misalign = |off[1:0];
            end
            LD_BU: data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            LD_HU: begin
                data     = {{(XLEN-16){1'b0}}, shifted[15:0]};
                misalign = off[0];
            end
            LD_WU: begin
                data     = {{(XLEN-32){1'b0}}, shifted[31:0]};
                misalign = |off[1:0];
            end
            default: begin
                // ld and the unused 111 encoding both return the whole doubleword
                data     = rdata;
                misalign = |off;
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, writeback source select, forwarding tap and retired-instruction counter.
module wb_stage #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic                  mem_regWrite,
    input  logic [1:0]            mem_wbSel,
    input  logic [2:0]            mem_funct3,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_aluResult,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic [XLEN-1:0]       mem_pcPlus4,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  regWrite,
    output logic [REG_ADDR_W-1:0] writeReg,
    output logic [XLEN-1:0]       writeData,
    output logic                  fwdValid,
    output logic [REG_ADDR_W-1:0] fwdReg,
    output logic [XLEN-1:0]       fwdData,
    output logic                  misalignErr,
    output logic [CNT_W-1:0]      instret
);
    import wb_stage_pkg::*;

    logic                  vld_p0;
    logic                  regwrite_p0;
    wb_sel_e               wbsel_p0;
    logic [2:0]            funct3_p0;
    logic [REG_ADDR_W-1:0] rd_p0;
    logic [XLEN-1:0]       alu_p0;
    logic [XLEN-1:0]       rdata_p0;
    logic [XLEN-1:0]       pc4_p0;
    logic [CNT_W-1:0]      instret_cnt;

    logic [XLEN-1:0] load_data;
    logic            load_misalign;
    logic            retire;

    assign retire = mem_valid & ~stall & ~flush;

    // MEM -> WB boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0      <= 1'b0;
            regwrite_p0 <= 1'b0;
            wbsel_p0    <= WB_ALU;
            funct3_p0   <= '0;
            rd_p0       <= '0;
            alu_p0      <= '0;
            rdata_p0    <= '0;
            pc4_p0      <= '0;
            instret_cnt <= '0;
        end else begin
            if (flush) begin
                vld_p0 <= 1'b0;
            end else if (!stall) begin
                vld_p0      <= mem_valid;
                regwrite_p0 <= mem_regWrite;
                wbsel_p0    <= wb_sel_e'(mem_wbSel);
                funct3_p0   <= mem_funct3;
                rd_p0       <= mem_rd;
                alu_p0      <= mem_aluResult;
                rdata_p0    <= mem_rdata;
                pc4_p0      <= mem_pcPlus4;
            end
            if (retire) begin
                instret_cnt <= instret_cnt + 1'b1;
            end
        end
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata    (rdata_p0),
        .off      (alu_p0[2:0]),
        .funct3   (funct3_p0),
        .data     (load_data),
        .misalign (load_misalign)
    );

    always_comb begin
        case (wbsel_p0)
            WB_MEM:  writeData = load_data;
            WB_PC4:  writeData = pc4_p0;
            default: writeData = alu_p0;
        endcase
    end

    assign misalignErr = vld_p0 & (wbsel_p0 == WB_MEM) & load_misalign;
    assign regWrite    = vld_p0 & regwrite_p0 & (rd_p0 != '0) & ~misalignErr;
    assign writeReg    = rd_p0;
    assign fwdValid    = regWrite;
    assign fwdReg      = writeReg;
    assign fwdData     = writeData;
    assign instret     = instret_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a per-cycle reference model plus hand-computed literal checks.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_regWrite;
    logic [1:0]  mem_wbSel;
    logic [2:0]  mem_funct3;
    logic [4:0]  mem_rd;
    logic [63:0] mem_aluResult;
    logic [63:0] mem_rdata;
    logic [63:0] mem_pcPlus4;
    logic        stall;
    logic        flush;

    logic        regWrite, fwdValid, misalignErr;
    logic [4:0]  writeReg, fwdReg;
    logic [63:0] writeData, fwdData, instret;

    logic        regWrite_w, fwdValid_w, misalignErr_w;
    logic [4:0]  writeReg_w, fwdReg_w;
    logic [63:0] writeData_w, fwdData_w;
    logic [3:0]  instret_w;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_regWrite(mem_regWrite),
        .mem_wbSel(mem_wbSel), .mem_funct3(mem_funct3), .mem_rd(mem_rd),
        .mem_aluResult(mem_aluResult), .mem_rdata(mem_rdata), .mem_pcPlus4(mem_pcPlus4),
        .stall(stall), .flush(flush), .regWrite(regWrite), .writeReg(writeReg),
        .writeData(writeData), .fwdValid(fwdValid), .fwdReg(fwdReg), .fwdData(fwdData),
        .misalignErr(misalignErr), .instret(instret)
    );

    // Narrow-counter instance so wrap-around is reachable in a short run.
    wb_stage #(.CNT_W(4)) dutw (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_regWrite(mem_regWrite),
        .mem_wbSel(mem_wbSel), .mem_funct3(mem_funct3), .mem_rd(mem_rd),
        .mem_aluResult(mem_aluResult), .mem_rdata(mem_rdata), .mem_pcPlus4(mem_pcPlus4),
        .stall(stall), .flush(flush), .regWrite(regWrite_w), .writeReg(writeReg_w),
        .writeData(writeData_w), .fwdValid(fwdValid_w), .fwdReg(fwdReg_w), .fwdData(fwdData_w),
        .misalignErr(misalignErr_w), .instret(instret_w)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int load_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b11) return 8;
        return 1 << f3[1:0];
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] rd, input int off, input logic [2:0] f3);
        int          sz;
        logic [63:0] v, mask;
        sz = load_size(f3);
        if (sz == 8) return rd;
        v    = rd >> (8 * off);
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v    = v & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // Reference model: what WB holds after each posedge
    bit          m_vld, m_rwe, m_mis;
    logic [4:0]  m_rd;
    logic [63:0] m_data, m_cnt;

    always @(posedge clk) begin
        int off;
        if (rst) begin
            m_vld = 0; m_rwe = 0; m_mis = 0; m_rd = 0; m_data = 0; m_cnt = 0;
        end else begin
            if (flush) begin
                m_vld = 0;
            end else if (!stall) begin
                off   = int'(mem_aluResult % 8);
                m_vld = mem_valid;
                m_rwe = mem_regWrite;
                m_rd  = mem_rd;
                m_mis = 0;
                if (mem_wbSel == 2'b01) begin
                    m_data = model_load(mem_rdata, off, mem_funct3);
                    m_mis  = (off % load_size(mem_funct3)) != 0;
                end else if (mem_wbSel == 2'b10) begin
                    m_data = mem_pcPlus4;
                end else begin
                    m_data = mem_aluResult;
                end
            end
            if (mem_valid && !stall && !flush) m_cnt = m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        bit exp_rw, exp_mis;
        if (chk_on) begin
            exp_mis = m_vld && m_mis;
            exp_rw  = m_vld && m_rwe && (m_rd != 0) && !exp_mis;
            chk("regWrite", {63'd0, regWrite}, {63'd0, exp_rw});
            chk("fwdValid", {63'd0, fwdValid}, {63'd0, exp_rw});
            chk("misalignErr", {63'd0, misalignErr}, {63'd0, exp_mis});
            chk("instret", instret, m_cnt);
            chk("instret_w", {60'd0, instret_w}, {60'd0, m_cnt[3:0]});
            chk("regWrite_w", {63'd0, regWrite_w}, {63'd0, exp_rw});
            if (m_vld) begin
                chk("writeReg", {59'd0, writeReg}, {59'd0, m_rd});
                chk("fwdReg", {59'd0, fwdReg}, {59'd0, m_rd});
                if (!exp_mis) begin
                    chk("writeData", writeData, m_data);
                    chk("fwdData", fwdData, m_data);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic v, input logic rw, input logic [1:0] sel, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] rdat,
                      input logic [63:0] pc4);
        mem_valid = v; mem_regWrite = rw; mem_wbSel = sel; mem_funct3 = f3;
        mem_rd = rd; mem_aluResult = alu; mem_rdata = rdat; mem_pcPlus4 = pc4;
        cyc();
    endtask

    initial begin
        logic [63:0] base;
        rst = 1; stall = 0; flush = 0;
        mem_valid = 0; mem_regWrite = 0; mem_wbSel = 0; mem_funct3 = 0;
        mem_rd = 0; mem_aluResult = 0; mem_rdata = 0; mem_pcPlus4 = 0;
        cyc();
        chk_on = 1'b1;
        cyc();
        chk("rst_regWrite", {63'd0, regWrite}, 64'd0);
        chk("rst_writeReg", {59'd0, writeReg}, 64'd0);
        chk("rst_writeData", writeData, 64'd0);
        chk("rst_misalign", {63'd0, misalignErr}, 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_fwdData", fwdData, 64'd0);
        rst = 0;

        // lb sign-extends 0x80
        op(1, 1, 2'b01, 3'b000, 5'd5, 64'h1000, 64'h80, 64'h0);
        chk("lb_rw", {63'd0, regWrite}, 64'd1);
        chk("lb_reg", {59'd0, writeReg}, 64'd5);
        chk("lb_data", writeData, 64'hFFFFFFFFFFFFFF80);

        op(1, 1, 2'b01, 3'b101, 5'd6, 64'h1006, 64'hBEEF000000000000, 64'h0);
        chk("lhu_data", writeData, 64'h000000000000BEEF);
        op(1, 1, 2'b01, 3'b010, 5'd6, 64'h1004, 64'h8000000100000000, 64'h0);
        chk("lw_data", writeData, 64'hFFFFFFFF80000001);

        base = instret;
        op(1, 1, 2'b01, 3'b010, 5'd8, 64'h1002, 64'h1122334455667788, 64'h0);
        chk("mis_err", {63'd0, misalignErr}, 64'd1);
        chk("mis_rw", {63'd0, regWrite}, 64'd0);
        chk("mis_cnt", instret, base + 64'd1);
        op(1, 1, 2'b00, 3'b000, 5'd0, 64'h55, 64'h0, 64'h0);
        chk("x0_rw", {63'd0, regWrite}, 64'd0);

        // every funct3 at every byte offset, model-checked each cycle
        for (int f = 0; f < 8; f++) begin
            for (int o = 0; o < 8; o++) begin
                op(1, 1, 2'b01, 3'(f), 5'(f + 1), 64'h2000 + 64'(o), 64'h8877F6E5D4C3B2A1, 64'h0);
            end
        end
        op(1, 1, 2'b11, 3'b000, 5'd3, 64'hCAFE, 64'h0, 64'h4);
        chk("sel11_data", writeData, 64'hCAFE);

        base = instret;
        op(1, 1, 2'b00, 3'b000, 5'd7, 64'h1234, 64'h0, 64'h0);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            op(1, 1, 2'b00, 3'b000, 5'd9, 64'h9999, 64'h0, 64'h0);
            chk("stall_reg", {59'd0, writeReg}, 64'd7);
            chk("stall_data", writeData, 64'h1234);
            chk("stall_rw", {63'd0, regWrite}, 64'd1);
        end
        chk("stall_cnt", instret, base + 64'd1);

        base = instret;
        flush = 1;
        op(1, 1, 2'b00, 3'b000, 5'd9, 64'h7777, 64'h0, 64'h0);
        chk("flush_rw", {63'd0, regWrite}, 64'd0);
        chk("flush_cnt", instret, base);
        flush = 0; stall = 0;
        op(1, 1, 2'b10, 3'b000, 5'd1, 64'hDEAD, 64'h0, 64'h1004);
        chk("jal_data", writeData, 64'h1004);
        op(0, 1, 2'b00, 3'b000, 5'd4, 64'h1, 64'h0, 64'h0);
        chk("bubble_rw", {63'd0, regWrite}, 64'd0);

        // counter wrap on the 4-bit instance after 16 retires from reset
        rst = 1;
        cyc();
        rst = 0;
        for (int i = 0; i < 16; i++) begin
            op(1, 1, 2'b00, 3'b000, 5'd2, 64'(i), 64'h0, 64'h0);
        end
        chk("wrap_w", {60'd0, instret_w}, 64'd0);
        chk("wrap_cnt", instret, 64'd16);

        rst = 1;
        op(1, 1, 2'b00, 3'b000, 5'd2, 64'hABCD, 64'h0, 64'h0);
        chk("midrst_rw", {63'd0, regWrite}, 64'd0);
        chk("midrst_data", writeData, 64'd0);
        chk("midrst_reg", {59'd0, writeReg}, 64'd0);
        chk("midrst_cnt", instret, 64'd0);
        rst = 0;
        op(0, 0, 2'b00, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
